soc_prio_int_ctl: RTL and testbench
===================================

Name: soc_prio_int_ctl

Overview:
Parametrised successor to the SoC interrupt controller, for core-side interrupt handling in the SoC controller peripheral. Adds per-channel edge/level mode, per-channel priority, a priority threshold, in-service tracking with nesting (preemption only by strictly higher priority), and a claim/complete handshake toward the core. Configured through a simple word-addressed register port that the owning peripheral bridges from the memory bus.

Parameters:
NUM_INTS, 32, number of interrupt channels (1..32)
PRIO_BITS, 3, priority field width (1..4); priority 0 means never asserted
ID_BITS, 5, width of channel id outputs; must satisfy 2**ID_BITS >= NUM_INTS

Ports:
clk  in  1  system clock
res  in  1  reset; asynchronous, active-high
int_triggers  in  NUM_INTS  raw interrupt sources, synchronous to clk
reg_addr  in  4  word index of register
reg_we  in  1  register write strobe, one cycle per write
reg_wdata  in  32  register write data
reg_rdata  out  32  register read data, combinational from reg_addr
irq_out  out  1  interrupt request to core, registered
irq_id  out  ID_BITS  id of winning channel, valid while irq_out=1, else 0
irq_claim  in  1  core claims irq_id this cycle
irq_complete  in  1  core finishes handler for complete_id
complete_id  in  ID_BITS  channel being completed

Behaviour:
- Register map by reg_addr: 0x0 ENABLE rw; 0x1 MODE rw (1=edge, 0=level); 0x2 PENDING read, write-1-to-clear; 0x3 INSERVICE read-only; 0x4 THRESHOLD rw in bits[PRIO_BITS-1:0]; 0x5 STATUS read-only {irq_out at bit 31, irq_id at low bits}; 0x8..0xB PRIO rw, 8 channels per word, 4-bit nibbles, channel 8*(addr-8)+k at bits[4k+PRIO_BITS-1:4k].
- Unmapped addresses read 0 and ignore writes. Bits for channels >= NUM_INTS read 0 and ignore writes. PRIO nibble bits above PRIO_BITS read 0.
- Reset (async): ENABLE, MODE, PENDING, INSERVICE, THRESHOLD, PRIO, trigger history = 0; irq_out=0, irq_id=0. A trigger already high when reset releases counts as a rising edge for edge-mode channels.
- Event, per channel i:
  - Edge mode: trig[i] & ~trig_prev[i].
  - Level mode: trig[i] & ~inservice[i].
  - Event sets pending[i] next cycle regardless of ENABLE.
  - Edge mode: an edge while in service queues exactly one pending.
- Priority of clearing: set beats clear. An event in the same cycle as a claim or PENDING W1C on the same channel leaves pending=1.
- Candidate i: pending & enable & ~inservice & prio[i]!=0 & prio[i]>THRESHOLD & prio[i] > max prio of all in-service channels.
- Winner: highest prio; ties go to the lowest index.
- irq_out/irq_id register the winner each cycle, giving 1-cycle latency from pending/config change to output.
- Claim: accepted only when irq_out=1; ignored otherwise. On claim of irq_id:
  - pending cleared and inservice set on the next edge.
  - irq_out, irq_id recomputed from the updated state, so irq_out may fall for one cycle.
  - Claim of a channel disabled in the same cycle is still honoured, because it uses the registered id.
- Complete: clears inservice[complete_id]. Ignored if that channel is not in service or complete_id >= NUM_INTS. Claim and complete in the same cycle both apply; same channel in both: the claim's set wins.
- Disabling a channel masks it from arbitration but keeps pending. Re-enabling with pending=1 asserts within 1 cycle.
- Register writes take effect on the next edge. reg_rdata reflects registered state, with no bypass.

Test Plan:
- Reset, ENABLE=0x1, MODE=0x1, PRIO ch0=3, pulse trig[0] one cycle -> PENDING=0x1 after 1 cycle, irq_out=1 with irq_id=0 one cycle later; claim -> PENDING=0, INSERVICE=0x1, irq_out=0; complete id 0 -> INSERVICE=0.
- ch2 prio 2, ch5 prio 5, ch7 prio 5, all edge, triggered together -> irq_id=5 (tie with 7, lower index wins); claim -> irq_out=0 because 7 does not exceed in-service prio 5; complete 5 -> irq_id=7; claim/complete -> irq_id=2.
- Nesting: ch1 prio 2 claimed, then ch3 prio 4 triggers -> irq_id=3 asserted while ch1 in service; ch4 prio 2 triggers -> not asserted until both complete.
- Level ch6 prio 1, trig held high -> claim clears pending, no re-pend while in service; complete with trig still high -> pending=1 next cycle and irq re-asserts; THRESHOLD=1 -> irq_out stays 0.
- Edge ch0: new edge in the same cycle as claim -> pending stays 1; write PENDING=0x1 in the same cycle as a new edge -> pending stays 1; write 0xFFFFFFFF to ENABLE with NUM_INTS=8 -> reads 0x000000FF.
- Assert res mid-service (irq_out=1, INSERVICE!=0) -> all registers and outputs 0 immediately without a clock; trig held high at release in edge mode -> pending set on the first edge.

Source files
------------

// File: rtl/soc_prio_int_ctl_if.sv
// Interrupt controller bus bundle: raw triggers, register port, core claim/complete.
// Latency: wiring only.
// Backpressure: none. The core paces claims and completes; register writes are single-cycle strobes.
// master: the peripheral/core side that drives triggers, register accesses and claim/complete.
// slave : the controller. It returns read data and the registered irq_out/irq_id.
interface soc_prio_int_ctl_if #(
    parameter int NUM_INTS = 32,
    parameter int ID_BITS  = 5
);
    logic [NUM_INTS-1:0] int_triggers;
    logic [3:0]          reg_addr;
    logic                reg_we;
    logic [31:0]         reg_wdata;
    logic [31:0]         reg_rdata;
    logic                irq_out;
    logic [ID_BITS-1:0]  irq_id;
    logic                irq_claim;
    logic                irq_complete;
    logic [ID_BITS-1:0]  complete_id;

    modport master (
        output int_triggers, reg_addr, reg_we, reg_wdata,
               irq_claim, irq_complete, complete_id,
        input  reg_rdata, irq_out, irq_id
    );

    modport slave (
        input  int_triggers, reg_addr, reg_we, reg_wdata,
               irq_claim, irq_complete, complete_id,
        output reg_rdata, irq_out, irq_id
    );
endinterface

// File: rtl/soc_prio_int_ctl.sv
// Priority interrupt controller. It supports edge/level channels, per-channel priority,
// a threshold, and nested in-service tracking with claim/complete.
// Latency: 1 cycle from a pending or config change to irq_out/irq_id.
// A claim is reflected in the arbitration at the same edge that records it.
// Backpressure: none. The core claims whenever irq_out=1. Register writes land on the next edge.
// Ports: clk, res (async, active-high) and bus (slave modport).
// The bus carries int_triggers, reg_addr/reg_we/reg_wdata/reg_rdata,
// irq_out/irq_id, irq_claim, irq_complete and complete_id.
module soc_prio_int_ctl #(
    parameter int NUM_INTS  = 32,
    parameter int PRIO_BITS = 3,
    parameter int ID_BITS   = 5
) (
    input  logic              clk,
    input  logic              res,
    soc_prio_int_ctl_if.slave bus
);

    typedef logic [PRIO_BITS-1:0] prio_t;

    localparam logic [3:0] A_ENABLE    = 4'h0;
    localparam logic [3:0] A_MODE      = 4'h1;
    localparam logic [3:0] A_PENDING   = 4'h2;
    localparam logic [3:0] A_INSERVICE = 4'h3;
    localparam logic [3:0] A_THRESHOLD = 4'h4;
    localparam logic [3:0] A_STATUS    = 4'h5;

    // Architectural state
    logic [NUM_INTS-1:0] enable_q, enable_d;
    logic [NUM_INTS-1:0] mode_q, mode_d;
    logic [NUM_INTS-1:0] pending_q, pending_d;
    logic [NUM_INTS-1:0] inservice_q, inservice_d;
    logic [NUM_INTS-1:0] trig_prev_q;
    prio_t [NUM_INTS-1:0] prio_q, prio_d;
    prio_t               thresh_q, thresh_d;
    logic                irq_out_q, irq_out_d;
    logic [ID_BITS-1:0]  irq_id_q, irq_id_d;

    // Per-cycle decode
    logic                claim_acc;
    logic [NUM_INTS-1:0] claim_mask;
    logic [NUM_INTS-1:0] comp_mask;
    logic [NUM_INTS-1:0] w1c_mask;
    logic [NUM_INTS-1:0] edge_ev;
    logic [NUM_INTS-1:0] level_ev;
    logic [NUM_INTS-1:0] event_vec;
    logic [NUM_INTS-1:0] arb_pend;
    logic [NUM_INTS-1:0] arb_is;
    prio_t               max_is_prio;
    prio_t               best_prio;
    logic [31:0]         rdata;

    // A claim is only meaningful while irq_out is up. It names the registered id,
    // so a same-cycle disable cannot retract it.
    always_comb begin
        claim_acc  = bus.irq_claim & irq_out_q;
        claim_mask = '0;
        comp_mask  = '0;
        for (int i = 0; i < NUM_INTS; i++) begin
            if (claim_acc && (irq_id_q == ID_BITS'(i))) begin
                claim_mask[i] = 1'b1;
            end
            // Ids >= NUM_INTS match no channel, so they are dropped here.
            if (bus.irq_complete && (bus.complete_id == ID_BITS'(i))) begin
                comp_mask[i] = 1'b1;
            end
        end
    end

    // Register writes
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        prio_d   = prio_q;
        w1c_mask = '0;
        if (bus.reg_we) begin
            case (bus.reg_addr)
                A_ENABLE:    enable_d = bus.reg_wdata[NUM_INTS-1:0];
                A_MODE:      mode_d   = bus.reg_wdata[NUM_INTS-1:0];
                A_PENDING:   w1c_mask = bus.reg_wdata[NUM_INTS-1:0];
                A_THRESHOLD: thresh_d = bus.reg_wdata[PRIO_BITS-1:0];
                default: begin
                    // PRIO words 0x8..0xB: eight 4-bit nibbles per word.
                    // Only the low PRIO_BITS of each nibble are stored.
                    for (int i = 0; i < NUM_INTS; i++) begin
                        if (bus.reg_addr == 4'(8 + i / 8)) begin
                            prio_d[i] = bus.reg_wdata[4 * (i % 8) +: PRIO_BITS];
                        end
                    end
                end
            endcase
        end
    end

    // Pending / in-service next state
    always_comb begin
        // On a claim and complete of the same channel, the claim's set wins.
        inservice_d = (inservice_q & ~comp_mask) | claim_mask;
        edge_ev     = bus.int_triggers & ~trig_prev_q;
        // Level sources are gated by next-cycle in-service status.
        // Claiming a held level line therefore clears it cleanly.
        // Completing it re-pends on the same edge that drops in-service.
        level_ev    = bus.int_triggers & ~inservice_d;
        event_vec   = (mode_q & edge_ev) | (~mode_q & level_ev);
        // Sets beat clears: a fresh event survives a same-cycle claim or W1C.
        pending_d   = (pending_q & ~claim_mask & ~w1c_mask) | event_vec;
    end

    // Arbitration. A claim takes effect here at once, so irq_out never presents
    // the just-claimed id a second time.
    always_comb begin
        arb_pend    = pending_q & ~claim_mask;
        arb_is      = inservice_q | claim_mask;
        max_is_prio = '0;
        for (int i = 0; i < NUM_INTS; i++) begin
            if (arb_is[i] && (prio_q[i] > max_is_prio)) begin
                max_is_prio = prio_q[i];
            end
        end
        irq_out_d = 1'b0;
        irq_id_d  = '0;
        best_prio = '0;
        // Ascending scan with a strict compare, so ties go to the lower index.
        for (int i = 0; i < NUM_INTS; i++) begin
            if (arb_pend[i] && enable_q[i] && (prio_q[i] != '0) &&
                (prio_q[i] > thresh_q) && (prio_q[i] > max_is_prio) &&
                (prio_q[i] > best_prio)) begin
                irq_out_d = 1'b1;
                irq_id_d  = ID_BITS'(i);
                best_prio = prio_q[i];
            end
        end
    end

    // Read mux: registered state only, no write bypass.
    always_comb begin
        rdata = '0;
        case (bus.reg_addr)
            A_ENABLE:    rdata[NUM_INTS-1:0]  = enable_q;
            A_MODE:      rdata[NUM_INTS-1:0]  = mode_q;
            A_PENDING:   rdata[NUM_INTS-1:0]  = pending_q;
            A_INSERVICE: rdata[NUM_INTS-1:0]  = inservice_q;
            A_THRESHOLD: rdata[PRIO_BITS-1:0] = thresh_q;
            A_STATUS: begin
                rdata[31]           = irq_out_q;
                rdata[ID_BITS-1:0]  = irq_id_q;
            end
            default: begin
                for (int i = 0; i < NUM_INTS; i++) begin
                    if (bus.reg_addr == 4'(8 + i / 8)) begin
                        rdata[4 * (i % 8) +: PRIO_BITS] = prio_q[i];
                    end
                end
            end
        endcase
    end

    // trig_prev resets to 0. A line already high at release then looks like a rising edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pending_q   <= '0;
            inservice_q <= '0;
            trig_prev_q <= '0;
            prio_q      <= '0;
            thresh_q    <= '0;
            irq_out_q   <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            trig_prev_q <= bus.int_triggers;
            prio_q      <= prio_d;
            thresh_q    <= thresh_d;
            irq_out_q   <= irq_out_d;
            irq_id_q    <= irq_id_d;
        end
    end

    assign bus.reg_rdata = rdata;
    assign bus.irq_out   = irq_out_q;
    assign bus.irq_id    = irq_id_q;

endmodule

// File: tb/tb_soc_prio_int_ctl.sv
// Directed bench for soc_prio_int_ctl with 8 channels, 3-bit priority and 4-bit ids.
// Inputs change 1 time unit after the rising edge, and outputs are sampled there too.
// Clock period is 100, so a handful of #1 register reads fit inside one cycle.
module tb_soc_prio_int_ctl;
    localparam int N  = 8;
    localparam int PB = 3;
    localparam int IB = 4;

    logic clk = 1'b0;
    logic res;
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rv;

    soc_prio_int_ctl_if #(.NUM_INTS(N), .ID_BITS(IB)) bus ();

    soc_prio_int_ctl #(.NUM_INTS(N), .PRIO_BITS(PB), .ID_BITS(IB)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_we    = 1'b1;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_rdata;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        bus.int_triggers = m;
        tick();
        bus.int_triggers = '0;
    endtask

    task automatic claim();
        bus.irq_claim = 1'b1;
        tick();
        bus.irq_claim = 1'b0;
    endtask

    task automatic complete(input logic [IB-1:0] id);
        bus.irq_complete = 1'b1;
        bus.complete_id  = id;
        tick();
        bus.irq_complete = 1'b0;
    endtask

    task automatic do_reset();
        bus.int_triggers = '0;
        bus.irq_claim    = 1'b0;
        bus.irq_complete = 1'b0;
        bus.reg_we       = 1'b0;
        res = 1'b1;
        tick();
        res = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] al [7];
        al = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8};
        res = 1'b1;
        bus.int_triggers = '0; bus.reg_addr = '0; bus.reg_we = 1'b0; bus.reg_wdata = '0;
        bus.irq_claim = 1'b0; bus.irq_complete = 1'b0; bus.complete_id = '0;
        #20;
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL reset_irq_out got %b want 0", bus.irq_out); end
        n_vec++; if (bus.irq_id !== 4'h0) begin n_err++; $display("FAIL reset_irq_id got %h want 0", bus.irq_id); end
        for (int k = 0; k < 7; k++) begin
            rd(al[k], rv);
            n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL reset_reg%0h got %h want 0", al[k], rv); end
        end
        tick();
        res = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        wr(4'h0, 32'h1); wr(4'h1, 32'h1); wr(4'h8, 32'h3);
        pulse(8'h01);
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h1) begin n_err++; $display("FAIL basic_pending got %h want 1", rv); end
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL basic_irq_early got %b want 0", bus.irq_out); end
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h0) begin n_err++; $display("FAIL basic_irq got %b/%h want 1/0", bus.irq_out, bus.irq_id); end
        rd(4'h5, rv);
        n_vec++; if (rv !== 32'h8000_0000) begin n_err++; $display("FAIL basic_status got %h want 80000000", rv); end
        claim();
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL basic_claim_pending got %h want 0", rv); end
        rd(4'h3, rv);
        n_vec++; if (rv !== 32'h1) begin n_err++; $display("FAIL basic_claim_inservice got %h want 1", rv); end
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL basic_claim_irq got %b want 0", bus.irq_out); end
        complete(4'h0);
        rd(4'h3, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL basic_complete got %h want 0", rv); end
        // A claim with irq_out low must be ignored.
        claim();
        rd(4'h3, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL basic_idle_claim got %h want 0", rv); end
    endtask

    task automatic test_priority();
        do_reset();
        wr(4'h0, 32'hFF); wr(4'h1, 32'hFF); wr(4'h8, 32'h5050_0200);
        rd(4'h8, rv);
        n_vec++; if (rv !== 32'h5050_0200) begin n_err++; $display("FAIL prio_readback got %h want 50500200", rv); end
        pulse(8'hA4);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h5) begin n_err++; $display("FAIL prio_tie got %b/%h want 1/5", bus.irq_out, bus.irq_id); end
        claim();
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL prio_no_equal_preempt got %b want 0", bus.irq_out); end
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h84) begin n_err++; $display("FAIL prio_pending got %h want 84", rv); end
        complete(4'h5);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h7) begin n_err++; $display("FAIL prio_ch7 got %b/%h want 1/7", bus.irq_out, bus.irq_id); end
        claim();
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL prio_ch2_blocked got %b want 0", bus.irq_out); end
        complete(4'h7);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h2) begin n_err++; $display("FAIL prio_ch2 got %b/%h want 1/2", bus.irq_out, bus.irq_id); end
    endtask

    task automatic test_nesting();
        do_reset();
        wr(4'h0, 32'hFF); wr(4'h1, 32'hFF); wr(4'h8, 32'h0002_4020);
        pulse(8'h02);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h1) begin n_err++; $display("FAIL nest_ch1 got %b/%h want 1/1", bus.irq_out, bus.irq_id); end
        claim();
        pulse(8'h08);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h3) begin n_err++; $display("FAIL nest_preempt got %b/%h want 1/3", bus.irq_out, bus.irq_id); end
        claim();
        pulse(8'h10);
        tick();
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL nest_ch4_masked got %b want 0", bus.irq_out); end
        complete(4'h3);
        tick();
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL nest_ch4_equal got %b want 0", bus.irq_out); end
        complete(4'h1);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h4) begin n_err++; $display("FAIL nest_ch4 got %b/%h want 1/4", bus.irq_out, bus.irq_id); end
    endtask

    task automatic test_level();
        do_reset();
        wr(4'h0, 32'h40); wr(4'h8, 32'h0100_0000);
        bus.int_triggers = 8'h40;
        tick();
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h6) begin n_err++; $display("FAIL level_irq got %b/%h want 1/6", bus.irq_out, bus.irq_id); end
        claim();
        tick(); tick();
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL level_no_repend got %h want 0", rv); end
        complete(4'h6);
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h40) begin n_err++; $display("FAIL level_repend got %h want 40", rv); end
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h6) begin n_err++; $display("FAIL level_reassert got %b/%h want 1/6", bus.irq_out, bus.irq_id); end
        wr(4'h4, 32'h1);
        tick();
        n_vec++; if (bus.irq_out !== 1'b0) begin n_err++; $display("FAIL level_threshold got %b want 0", bus.irq_out); end
        wr(4'h4, 32'h0); wr(4'h0, 32'h0);
        tick();
        rd(4'h2, rv);
        n_vec++; if (bus.irq_out !== 1'b0 || rv !== 32'h40) begin n_err++; $display("FAIL level_disable got %b/%h want 0/40", bus.irq_out, rv); end
        wr(4'h0, 32'h40);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h6) begin n_err++; $display("FAIL level_reenable got %b/%h want 1/6", bus.irq_out, bus.irq_id); end
        bus.int_triggers = '0;
    endtask

    task automatic test_set_beats_clear();
        do_reset();
        wr(4'h0, 32'h1); wr(4'h1, 32'h1); wr(4'h8, 32'h3);
        pulse(8'h01);
        tick();
        bus.int_triggers = 8'h01;
        claim();
        bus.int_triggers = 8'h00;
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h1) begin n_err++; $display("FAIL sbc_claim_pending got %h want 1", rv); end
        rd(4'h3, rv);
        n_vec++; if (rv !== 32'h1) begin n_err++; $display("FAIL sbc_claim_inservice got %h want 1", rv); end
        tick();
        bus.int_triggers = 8'h01;
        wr(4'h2, 32'h1);
        bus.int_triggers = 8'h00;
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h1) begin n_err++; $display("FAIL sbc_w1c_pending got %h want 1", rv); end
        wr(4'h2, 32'h1);
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL sbc_w1c_clear got %h want 0", rv); end
        complete(4'h9);
        complete(4'h8);
        rd(4'h3, rv);
        n_vec++; if (rv !== 32'h1) begin n_err++; $display("FAIL sbc_bad_complete got %h want 1", rv); end
        complete(4'h0);
        rd(4'h3, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL sbc_complete got %h want 0", rv); end
    endtask

    task automatic test_regs();
        do_reset();
        wr(4'h0, 32'hFFFF_FFFF); rd(4'h0, rv);
        n_vec++; if (rv !== 32'h0000_00FF) begin n_err++; $display("FAIL regs_enable got %h want ff", rv); end
        wr(4'h1, 32'hFFFF_FFFF); rd(4'h1, rv);
        n_vec++; if (rv !== 32'h0000_00FF) begin n_err++; $display("FAIL regs_mode got %h want ff", rv); end
        wr(4'h8, 32'hFFFF_FFFF); rd(4'h8, rv);
        n_vec++; if (rv !== 32'h7777_7777) begin n_err++; $display("FAIL regs_prio got %h want 77777777", rv); end
        wr(4'h9, 32'hFFFF_FFFF); rd(4'h9, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL regs_prio_hi got %h want 0", rv); end
        wr(4'h4, 32'hFFFF_FFFF); rd(4'h4, rv);
        n_vec++; if (rv !== 32'h7) begin n_err++; $display("FAIL regs_threshold got %h want 7", rv); end
        wr(4'h6, 32'hFFFF_FFFF); rd(4'h6, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL regs_unmapped got %h want 0", rv); end
        wr(4'h3, 32'hFFFF_FFFF); rd(4'h3, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL regs_inservice_ro got %h want 0", rv); end
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(4'h0, 32'h3); wr(4'h1, 32'h3); wr(4'h8, 32'h53);
        pulse(8'h01);
        tick();
        claim();
        pulse(8'h02);
        tick();
        n_vec++; if (bus.irq_out !== 1'b1 || bus.irq_id !== 4'h1) begin n_err++; $display("FAIL areset_pre got %b/%h want 1/1", bus.irq_out, bus.irq_id); end
        #10;
        res = 1'b1;
        #5;
        n_vec++; if (bus.irq_out !== 1'b0 || bus.irq_id !== 4'h0) begin n_err++; $display("FAIL areset_irq got %b/%h want 0/0", bus.irq_out, bus.irq_id); end
        rd(4'h3, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL areset_inservice got %h want 0", rv); end
        rd(4'h0, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL areset_enable got %h want 0", rv); end
        rd(4'h8, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL areset_prio got %h want 0", rv); end
        bus.int_triggers = 8'h01;
        #2;
        res = 1'b0;
        tick();
        rd(4'h2, rv);
        n_vec++; if (rv !== 32'h1) begin n_err++; $display("FAIL areset_release_pending got %h want 1", rv); end
        bus.int_triggers = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_level();
        test_set_beats_clear();
        test_regs();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
